// File: rtl/fadd_sched_pkg.sv
// Shared types for the fadd scheduler: float word and the tag that follows an op down the fadd.
package fadd_sched_pkg;

  localparam int FLOAT_W  = 32;
  localparam int NREQ_MAX = 16;
  localparam int ID_W     = $clog2(NREQ_MAX);

  typedef logic [FLOAT_W-1:0] float_t;

  // id is sized for the largest supported NREQ so one tag type serves every instance
  typedef struct packed {
    logic            v;
    logic [ID_W-1:0] id;
  } fadd_tag_t;

endpackage

// File: rtl/fadd.sv
// Two-stage single-precision adder: align/add, then normalise. Truncating, no NaN/Inf inputs,
// denormals treated as having an implicit 0; no valid/ready, a result emerges 2 cycles after its operands.
module fadd
  import fadd_sched_pkg::*;
(
  input  logic   clk,
  input  float_t x1,
  input  float_t x2,
  output float_t y
);

  float_t      a, b;
  logic [23:0] ma, mb;
  logic [7:0]  d;
  logic [25:0] ax, bx;
  logic [26:0] sum_d;

  logic        s1_sign_q;
  logic [7:0]  s1_exp_q;
  logic [26:0] s1_sum_q;

  logic [4:0]        lz;
  logic [26:0]       sh;
  logic signed [9:0] e;
  float_t            y_d, y_q;

  always_comb begin
    a     = (x1[30:0] >= x2[30:0]) ? x1 : x2;
    b     = (x1[30:0] >= x2[30:0]) ? x2 : x1;
    ma    = {|a[30:23], a[22:0]};
    mb    = {|b[30:23], b[22:0]};
    d     = a[30:23] - b[30:23];
    ax    = {ma, 2'b00};
    bx    = (d > 8'd25) ? '0 : ({mb, 2'b00} >> d);
    sum_d = (a[31] == b[31]) ? ({1'b0, ax} + {1'b0, bx}) : ({1'b0, ax} - {1'b0, bx});
  end

  always_ff @(posedge clk) begin
    s1_sign_q <= a[31];
    s1_exp_q  <= a[30:23];
    s1_sum_q  <= sum_d;
  end

  // the implicit one of the larger operand sits at bit 25; carry-out lands at 26
  always_comb begin
    lz = 5'd0;
    for (int i = 0; i < 27; i++) begin
      if (s1_sum_q[i]) lz = 5'(26 - i);
    end
    sh = s1_sum_q << lz;
    e  = $signed({2'b00, s1_exp_q}) + 10'sd1 - $signed({5'b00000, lz});
    if (s1_sum_q == '0)        y_d = '0;
    else if (e <= 10'sd0)      y_d = {s1_sign_q, 31'b0};
    else if (e >= 10'sd255)    y_d = {s1_sign_q, 8'hFF, 23'b0};
    else                       y_d = {s1_sign_q, e[7:0], 23'(sh >> 3)};
  end

  always_ff @(posedge clk) begin
    y_q <= y_d;
  end

  assign y = y_q;

endmodule

// File: rtl/fadd_sched_rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first request at or after ptr.
// Pointer state lives in the caller.
module rr_arbiter #(
  parameter  int N  = 4,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt
);

  logic [N-1:0] rot;
  logic [N-1:0] first;

  // rotate so ptr sits at bit 0, isolate the lowest set bit, rotate back
  always_comb begin
    rot   = N'({req, req} >> ptr);
    first = rot & (~rot + N'(1));
    gnt   = N'({first, first} << ptr >> N);
  end

endmodule

// File: rtl/fadd_sched.sv
// Round-robin sharing of one fixed-latency fadd among NREQ requesters; result in FADD_LAT+1 cycles.
// A requester with an op in flight or an unconsumed result is not granted until its slot is read.
module fadd_sched
  import fadd_sched_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int FADD_LAT = 2
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic [NREQ-1:0]                req_valid,
  output logic [NREQ-1:0]                req_ready,
  input  logic [NREQ-1:0][FLOAT_W-1:0]   req_x1,
  input  logic [NREQ-1:0][FLOAT_W-1:0]   req_x2,
  output logic [NREQ-1:0]                resp_valid,
  input  logic [NREQ-1:0]                resp_ready,
  output logic [NREQ-1:0][FLOAT_W-1:0]   resp_y,
  output logic [FLOAT_W-1:0]             fadd_x1,
  output logic [FLOAT_W-1:0]             fadd_x2,
  input  logic [FLOAT_W-1:0]             fadd_y
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]              inflight_q, inflight_d;
  logic [NREQ-1:0]              full_q, full_d;
  logic [NREQ-1:0]              elig, gnt, cap_hot;
  logic [PW-1:0]                ptr_q, ptr_d;
  float_t                       x1_q, x1_d, x2_q, x2_d;
  logic [NREQ-1:0][FLOAT_W-1:0] resp_y_q, resp_y_d;
  fadd_tag_t                    tag_q [FADD_LAT+1];
  fadd_tag_t                    tag_d, tag_out;

  assign elig = req_valid & ~inflight_q & ~full_q;

  rr_arbiter #(.N(NREQ)) u_arb (
    .req (elig),
    .ptr (ptr_q),
    .gnt (gnt)
  );

  // grant is combinational, so hold it low while reset is asserted
  assign req_ready  = gnt & {NREQ{rstn}};
  assign tag_out    = tag_q[FADD_LAT];
  assign resp_valid = full_q;
  assign resp_y     = resp_y_q;
  assign fadd_x1    = x1_q;
  assign fadd_x2    = x2_q;

  always_comb begin
    x1_d       = '0;
    x2_d       = '0;
    tag_d      = '0;
    ptr_d      = ptr_q;
    inflight_d = inflight_q;
    full_d     = full_q & ~resp_ready;
    resp_y_d   = resp_y_q;
    cap_hot    = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (req_ready[i]) begin
        x1_d          = req_x1[i];
        x2_d          = req_x2[i];
        tag_d.v       = 1'b1;
        tag_d.id      = ID_W'(i);
        ptr_d         = (i == NREQ - 1) ? '0 : PW'(i + 1);
        inflight_d[i] = 1'b1;
      end
      cap_hot[i] = tag_out.v && (tag_out.id == ID_W'(i));
      if (cap_hot[i]) begin
        resp_y_d[i]   = fadd_y;
        full_d[i]     = 1'b1;
        inflight_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      inflight_q <= '0;
      full_q     <= '0;
      ptr_q      <= '0;
      x1_q       <= '0;
      x2_q       <= '0;
      resp_y_q   <= '0;
      for (int k = 0; k <= FADD_LAT; k++) tag_q[k] <= '0;
    end else begin
      inflight_q <= inflight_d;
      full_q     <= full_d;
      ptr_q      <= ptr_d;
      x1_q       <= x1_d;
      x2_q       <= x2_d;
      resp_y_q   <= resp_y_d;
      tag_q[0]   <= tag_d;
      for (int k = 1; k <= FADD_LAT; k++) tag_q[k] <= tag_q[k-1];
    end
  end

  a_no_capture_into_full: assert property (@(posedge clk) disable iff (!rstn)
    (cap_hot & full_q) == '0);

  a_grant_onehot0: assert property (@(posedge clk) disable iff (!rstn)
    $onehot0(req_ready));

endmodule
